timer_unit: RTL and testbench
=============================

Name: timer_unit

Overview:
- Downstream peripheral of the control unit. Executes the TIM_* instructions.
- Holds a prescaler and an auto-reload up-counter. Reports an update event and keeps a sticky update flag for software polling.
- Sits beside the ALU. Consumes timer_en, alu_cntrl and the resolved operand (immediate or rs1 value) for the instruction being committed.

Parameters:
- CNT_W, 32, counter and auto-reload register (ARR) width.
- PSC_W, 16, prescaler register width. Operand bits above PSC_W are ignored.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  one-cycle strobe: the instruction on alu_cntrl commits this cycle.
- alu_cntrl  in  6  control-unit opcode.
- timer_en  in  1  level enable from the control unit. 1 = run, 0 = halt.
- operand  in  32  immediate or register value for the PSC/ARR writes.
- uif_clr  in  1  clears the sticky update flag.
- cnt_out  out  CNT_W  current counter value.
- psc_out  out  PSC_W  active prescaler value.
- arr_out  out  CNT_W  active auto-reload value.
- update  out  1  one-cycle pulse on counter wrap.
- uif  out  1  sticky update flag.
- running  out  1  high in RUN.

Behaviour:
- Reset (async): every register and output goes to 0. State = IDLE, psc = 0, arr = 0, cnt = 0, uif = 0.
- Write decode, only when instr_valid = 1:
  - 6'b100001 (TIM_PSC_I) or 6'b100011 (TIM_PSC_REG) writes psc_pre <= operand[PSC_W-1:0].
  - 6'b100010 (TIM_ARR_I) or 6'b100100 (TIM_ARR_REG) writes arr_pre <= operand[CNT_W-1:0].
  - Any other code is ignored.
- Preload to active (TIMER_PRELOAD_EN defined):
  - In IDLE, active psc/arr copy psc_pre/arr_pre every cycle.
  - In RUN, the copy happens only on the cycle of an update event.
  - If a write and an update fall in the same cycle, the active register takes the newly written value (bypass).
- FSM:
  - IDLE -> RUN on the clock edge where timer_en = 1.
  - RUN -> IDLE on the clock edge where timer_en = 0.
  - running = (state == RUN), registered.
- Prescaler, in RUN only:
  - psc_cnt increments every cycle.
  - When psc_cnt == psc: tick = 1 and psc_cnt <= 0.
  - psc = 0 gives a tick every cycle.
- Counter, on tick:
  - If cnt == arr: cnt <= 0 and an update event fires. Otherwise cnt <= cnt + 1.
  - arr = 0 makes every tick an update event; cnt stays 0.
- update is registered: it is high in the cycle after the tick that wrapped.
- uif is set on an update event and cleared by uif_clr. If set and clear coincide, set wins.
- Entering RUN clears psc_cnt. The first cnt increment occurs psc+1 cycles after running rises.
- Leaving RUN: cnt holds its value, psc_cnt clears, no further updates. Re-enabling resumes from the held cnt.
- Writing an ARR below the current cnt (immediate mode): cnt runs to 2^CNT_W-1, wraps to 0 with no update event, then continues normally.
- Reset mid-count aborts immediately and restores all reset values. No update pulse is produced.

Optional Feature:
- Macro: TIMER_PRELOAD_EN.
- Defined: shadow preload registers as described; PSC/ARR changes take effect only at update events while running.
- Undefined: psc_pre/arr_pre are not instantiated. Writes go directly to active psc/arr in the cycle after instr_valid, and the new value is compared from that cycle on.

Decomposition:
- Shared package timer_pkg holds:
  - localparams ALU_TIM_PSC_I, ALU_TIM_ARR_I, ALU_TIM_PSC_REG, ALU_TIM_ARR_REG, ALU_NOP (6'b111111), shared with the control unit;
  - typedef enum logic {TIM_IDLE, TIM_RUN} tim_state_t.
- One sub-module, tim_prescaler: psc_cnt plus tick generation, with inputs clk, reset, run, psc and output tick.

Test Plan:
1. PSC=0, ARR=3, timer_en=1 -> cnt goes 0,1,2,3,0. update pulses once every 4 cycles; uif=1 after the first wrap.
2. PSC=2, ARR=1 -> cnt advances every 3 cycles; update every 6 cycles. First increment 3 cycles after running rises.
3. PRELOAD_EN: ARR=5 running, write ARR=2 at cnt=1 -> cnt still reaches 5, then arr_out=2 on the wrap; next period is 3 ticks. Without the macro: arr_out=2 next cycle and the wrap occurs at cnt=2.
4. timer_en drops at cnt=7 for 10 cycles, then rises -> cnt holds 7, update stays 0, counting resumes 7->8 after psc+1 cycles.
5. uif_clr asserted in the same cycle as a wrap -> uif stays 1. uif_clr alone next cycle -> uif=0.
6. Assert reset mid-run with cnt=9, PSC=4 -> cnt, psc_out, arr_out, uif, running all 0 immediately (asynchronously); an instr_valid write during reset is ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: opcodes shared with the control unit and the timer FSM state type.
package timer_pkg;
    localparam logic [5:0] ALU_TIM_PSC_I   = 6'b100001;
    localparam logic [5:0] ALU_TIM_ARR_I   = 6'b100010;
    localparam logic [5:0] ALU_TIM_PSC_REG = 6'b100011;
    localparam logic [5:0] ALU_TIM_ARR_REG = 6'b100100;
    localparam logic [5:0] ALU_NOP         = 6'b111111;
    typedef enum logic {TIM_IDLE, TIM_RUN} tim_state_t;
endpackage

// File: rtl/tim_prescaler.sv
// tim_prescaler: divides the clock by psc+1 while run is high; restarts from 0 on every entry to run.
module tim_prescaler #(
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);
    logic [PSC_W-1:0] psc_cnt;
    assign tick = run && (psc_cnt == psc);
    always_ff @(posedge clk or posedge reset)
        if (reset) psc_cnt <= '0;
        else psc_cnt <= (run && !tick) ? psc_cnt + 1'b1 : '0;
endmodule

// File: rtl/timer_unit.sv
// timer_unit: prescaled auto-reload up-counter driven by the TIM_* instructions.
// Define TIMER_PRELOAD_EN to hold PSC/ARR writes in shadow registers until the next update event.
module timer_unit
    import timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [5:0]       alu_cntrl,
    input  logic             timer_en,
    input  logic [31:0]      operand,
    input  logic             uif_clr,
    output logic [CNT_W-1:0] cnt_out,
    output logic [PSC_W-1:0] psc_out,
    output logic [CNT_W-1:0] arr_out,
    output logic             update,
    output logic             uif,
    output logic             running
);
    tim_state_t state;
    logic tick, upd_evt, wr_psc, wr_arr;
    assign wr_psc  = instr_valid && (alu_cntrl == ALU_TIM_PSC_I || alu_cntrl == ALU_TIM_PSC_REG);
    assign wr_arr  = instr_valid && (alu_cntrl == ALU_TIM_ARR_I || alu_cntrl == ALU_TIM_ARR_REG);
    assign upd_evt = tick && (cnt_out == arr_out);

    tim_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk   (clk),
        .reset (reset),
        .run   (state == TIM_RUN),
        .psc   (psc_out),
        .tick  (tick)
    );

`ifdef TIMER_PRELOAD_EN
    logic [PSC_W-1:0] psc_pre, psc_nxt;
    logic [CNT_W-1:0] arr_pre, arr_nxt;
    // Write bypass: a write landing on an update cycle reaches the active register directly.
    assign psc_nxt = wr_psc ? operand[PSC_W-1:0] : psc_pre;
    assign arr_nxt = wr_arr ? operand[CNT_W-1:0] : arr_pre;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            psc_pre <= '0;
            arr_pre <= '0;
            psc_out <= '0;
            arr_out <= '0;
        end else begin
            psc_pre <= psc_nxt;
            arr_pre <= arr_nxt;
            if (state == TIM_IDLE || upd_evt) begin
                psc_out <= psc_nxt;
                arr_out <= arr_nxt;
            end
        end
`else
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            psc_out <= '0;
            arr_out <= '0;
        end else begin
            if (wr_psc) psc_out <= operand[PSC_W-1:0];
            if (wr_arr) arr_out <= operand[CNT_W-1:0];
        end
`endif

    // An ARR written below cnt lets cnt overflow to 0 naturally, without an update event.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= TIM_IDLE;
            running <= 1'b0;
            cnt_out <= '0;
            update  <= 1'b0;
            uif     <= 1'b0;
        end else begin
            state   <= timer_en ? TIM_RUN : TIM_IDLE;
            running <= timer_en;
            update  <= upd_evt;
            uif     <= upd_evt || (uif && !uif_clr);
            if (tick) cnt_out <= upd_evt ? '0 : cnt_out + 1'b1;
        end
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: scoreboard bench for timer_unit; expectations come from a closed-form tick model.
module tb_timer_unit;
    import timer_pkg::*;
    logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0, timer_en = 1'b0, uif_clr = 1'b0;
    logic [5:0]  alu_cntrl = ALU_NOP;
    logic [31:0] operand = '0;
    logic [31:0] cnt_out, arr_out;
    logic [15:0] psc_out;
    logic        update, uif, running;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] arr;
        logic        update;
        logic        uif;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    timer_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .alu_cntrl   (alu_cntrl),
        .timer_en    (timer_en),
        .operand     (operand),
        .uif_clr     (uif_clr),
        .cnt_out     (cnt_out),
        .psc_out     (psc_out),
        .arr_out     (arr_out),
        .update      (update),
        .uif         (uif),
        .running     (running)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        timer_en = 1'b0;
        instr_valid = 1'b0;
        uif_clr = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [5:0] op, input logic [31:0] v);
        instr_valid = 1'b1;
        alu_cntrl = op;
        operand = v;
        cyc();
        instr_valid = 1'b0;
        alu_cntrl = ALU_NOP;
        operand = '0;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (cnt_out !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt_out); end
        n_chk++; if (psc_out !== 16'd0) begin n_fail++; $display("FAIL reset_psc: got %0d expected 0", psc_out); end
        n_chk++; if (arr_out !== 32'd0) begin n_fail++; $display("FAIL reset_arr: got %0d expected 0", arr_out); end
        n_chk++; if ({update, uif, running} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {update, uif, running}); end
        cyc();
        reset = 1'b0;
    endtask

    // Cycle k after running rises has seen k/(p+1) ticks.
    task automatic test_periodic(input int p, input int a, input int n, input string name);
        do_reset();
        wr(ALU_TIM_PSC_I, p);
        wr(ALU_TIM_ARR_REG, a);
        n_chk++; if (psc_out !== 16'(p)) begin n_fail++; $display("FAIL %s psc_out: got %0d expected %0d", name, psc_out, p); end
        n_chk++; if (arr_out !== 32'(a)) begin n_fail++; $display("FAIL %s arr_out: got %0d expected %0d", name, arr_out, a); end
        timer_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t;
            t = k / (p + 1);
            sb.push_back('{cnt: 32'(t % (a + 1)), arr: 32'(a),
                           update: (k % (p + 1) == 0) && (t > 0) && (t % (a + 1) == 0), uif: t > a});
            cyc();
            e = sb.pop_front();
            n_chk++; if (cnt_out !== e.cnt) begin n_fail++; $display("FAIL %s cnt k=%0d: got %0d expected %0d", name, k, cnt_out, e.cnt); end
            n_chk++; if (update !== e.update) begin n_fail++; $display("FAIL %s update k=%0d: got %b expected %b", name, k, update, e.update); end
            n_chk++; if (uif !== e.uif) begin n_fail++; $display("FAIL %s uif k=%0d: got %b expected %b", name, k, uif, e.uif); end
            n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL %s running k=%0d: got %b expected 1", name, k, running); end
        end
        timer_en = 1'b0;
    endtask

    task automatic test_arr_write();
        logic u;
`ifdef TIMER_PRELOAD_EN
        int ec[8] = '{2, 3, 4, 5, 0, 1, 2, 0};
        int ea[8] = '{5, 5, 5, 5, 2, 2, 2, 2};
        int eu[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
`else
        int ec[5] = '{2, 0, 1, 2, 0};
        int ea[5] = '{2, 2, 2, 2, 2};
        int eu[5] = '{0, 1, 0, 0, 1};
`endif
        do_reset();
        wr(ALU_TIM_PSC_REG, 0);
        wr(ALU_TIM_ARR_I, 5);
        timer_en = 1'b1;
        cyc();
        cyc();
        n_chk++; if (cnt_out !== 32'd1) begin n_fail++; $display("FAIL arr_write pre cnt: got %0d expected 1", cnt_out); end
        u = 1'b0;
        foreach (ec[i]) begin
            u = u | (eu[i] != 0);
            sb.push_back('{cnt: 32'(ec[i]), arr: 32'(ea[i]), update: eu[i] != 0, uif: u});
        end
        instr_valid = 1'b1;
        alu_cntrl = ALU_TIM_ARR_I;
        operand = 32'd2;
        for (int k = 0; sb.size() > 0; k++) begin
            cyc();
            instr_valid = 1'b0;
            alu_cntrl = ALU_NOP;
            e = sb.pop_front();
            n_chk++; if (cnt_out !== e.cnt) begin n_fail++; $display("FAIL arr_write cnt k=%0d: got %0d expected %0d", k, cnt_out, e.cnt); end
            n_chk++; if (arr_out !== e.arr) begin n_fail++; $display("FAIL arr_write arr k=%0d: got %0d expected %0d", k, arr_out, e.arr); end
            n_chk++; if (update !== e.update) begin n_fail++; $display("FAIL arr_write update k=%0d: got %b expected %b", k, update, e.update); end
            n_chk++; if (uif !== e.uif) begin n_fail++; $display("FAIL arr_write uif k=%0d: got %b expected %b", k, uif, e.uif); end
        end
        timer_en = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        wr(ALU_TIM_PSC_I, 1);
        wr(ALU_TIM_ARR_I, 20);
        timer_en = 1'b1;
        repeat (15) cyc();
        n_chk++; if (cnt_out !== 32'd7) begin n_fail++; $display("FAIL halt pre cnt: got %0d expected 7", cnt_out); end
        timer_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            n_chk++; if ({cnt_out, update, running} !== {32'd7, 2'b00}) begin n_fail++; $display("FAIL halt hold k=%0d: got cnt=%0d upd=%b run=%b expected cnt=7 upd=0 run=0", k, cnt_out, update, running); end
        end
        timer_en = 1'b1;
        sb.push_back('{cnt: 32'd7, arr: 32'd20, update: 1'b0, uif: 1'b0});
        sb.push_back('{cnt: 32'd7, arr: 32'd20, update: 1'b0, uif: 1'b0});
        sb.push_back('{cnt: 32'd8, arr: 32'd20, update: 1'b0, uif: 1'b0});
        for (int k = 0; sb.size() > 0; k++) begin
            cyc();
            e = sb.pop_front();
            n_chk++; if (cnt_out !== e.cnt) begin n_fail++; $display("FAIL halt resume cnt k=%0d: got %0d expected %0d", k, cnt_out, e.cnt); end
            n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL halt resume running k=%0d: got %b expected 1", k, running); end
        end
        timer_en = 1'b0;
    endtask

    task automatic test_uif_clr();
        do_reset();
        wr(ALU_TIM_PSC_I, 0);
        wr(ALU_TIM_ARR_I, 3);
        timer_en = 1'b1;
        repeat (4) cyc();
        n_chk++; if ({cnt_out, uif} !== {32'd3, 1'b0}) begin n_fail++; $display("FAIL uif_clr pre: got cnt=%0d uif=%b expected cnt=3 uif=0", cnt_out, uif); end
        uif_clr = 1'b1;
        cyc();
        n_chk++; if ({update, uif} !== 2'b11) begin n_fail++; $display("FAIL uif_clr collide: got upd=%b uif=%b expected 1 1", update, uif); end
        cyc();
        n_chk++; if (uif !== 1'b0) begin n_fail++; $display("FAIL uif_clr alone: got %b expected 0", uif); end
        uif_clr = 1'b0;
        timer_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(ALU_TIM_PSC_I, 4);
        wr(ALU_TIM_ARR_I, 20);
        timer_en = 1'b1;
        repeat (46) cyc();
        n_chk++; if ({cnt_out, psc_out, running} !== {32'd9, 16'd4, 1'b1}) begin n_fail++; $display("FAIL reset_mid pre: got cnt=%0d psc=%0d run=%b expected 9 4 1", cnt_out, psc_out, running); end
        #2;
        reset = 1'b1;
        instr_valid = 1'b1;
        alu_cntrl = ALU_TIM_ARR_I;
        operand = 32'd7;
        #1;
        n_chk++; if (cnt_out !== 32'd0) begin n_fail++; $display("FAIL reset_mid async cnt: got %0d expected 0", cnt_out); end
        n_chk++; if ({psc_out, arr_out} !== 48'd0) begin n_fail++; $display("FAIL reset_mid async psc/arr: got %0d/%0d expected 0/0", psc_out, arr_out); end
        n_chk++; if ({update, uif, running} !== 3'b000) begin n_fail++; $display("FAIL reset_mid async flags: got %b expected 000", {update, uif, running}); end
        cyc();
        n_chk++; if (arr_out !== 32'd0) begin n_fail++; $display("FAIL reset_mid write ignored: got %0d expected 0", arr_out); end
        instr_valid = 1'b0;
        alu_cntrl = ALU_NOP;
        timer_en = 1'b0;
        reset = 1'b0;
        cyc();
        n_chk++; if ({cnt_out, arr_out, update, running} !== 66'd0) begin n_fail++; $display("FAIL reset_mid after: got cnt=%0d arr=%0d upd=%b run=%b expected all 0", cnt_out, arr_out, update, running); end
    endtask

    initial begin
        test_reset();
        test_periodic(0, 3, 12, "basic");
        test_periodic(2, 1, 20, "prescale");
        test_arr_write();
        test_halt();
        test_uif_clr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
